// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative HI/LO multiply/divide unit for the mips32 execute stage.
//   MULT/MULTU use a radix-2 shift-add multiplier; DIV/DIVU use restoring
//   division. Both run on operand magnitudes for 32 iterations, then a FIX
//   cycle applies the sign correction and writes HI/LO. Every operation
//   takes 33 cycles from acceptance to result.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   start      issue request, accepted only in IDLE
//   op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   rsData     operand A (multiplicand / dividend), also MTHI/MTLO data
//   rtData     operand B (multiplier / divisor)
//   mthi/mtlo  load rsData into HI/LO, honoured only in IDLE without start
//   hi/lo      architectural HI and LO registers
//   busy       high while an operation is in flight
//   done       one-cycle pulse when HI/LO take a new mult/div result
//   fsm_state  current FSM state (0 IDLE, 1 RUN, 2 FIX) for observation
//
// Handshake: start is a request with no ready; it is taken on the edge
// where the unit is IDLE (busy=0) and dropped otherwise. done pulses for
// exactly one cycle after the edge that writes the result into HI/LO.
module mult_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rsData,
  input  logic [31:0] rtData,
  input  logic        mthi,
  input  logic        mtlo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [31:0] a_reg;     // |A|; shifted left during divide to feed dividend bits
  logic [31:0] b_reg;     // |B|; shifted right during multiply to expose multiplier bits
  logic [63:0] work;      // multiply: running product; divide: {remainder, quotient}
  logic [5:0]  cnt;
  logic        neg_res;   // negate product / quotient in FIX
  logic        neg_rem;   // negate remainder in FIX

  // Operand preparation at issue
  logic        in_signed;
  logic        in_div;
  logic        a_neg_in;
  logic        b_neg_in;
  logic [31:0] a_mag_in;
  logic [31:0] b_mag_in;

  assign in_signed = ~op[0];
  assign in_div    = op[1];
  assign a_neg_in  = in_signed & rsData[31];
  assign b_neg_in  = in_signed & rtData[31];
  assign a_mag_in  = a_neg_in ? (~rsData + 32'd1) : rsData;
  assign b_mag_in  = b_neg_in ? (~rtData + 32'd1) : rtData;

  // Multiply step: add |A| into the upper half when the current multiplier
  // bit is set, then shift the whole product right by one.
  logic [32:0] mul_sum;
  assign mul_sum = {1'b0, work[63:32]} + {1'b0, (b_reg[0] ? a_reg : 32'd0)};

  // Divide step: shift the next dividend bit into the partial remainder and
  // try subtracting the divisor. The partial remainder stays below the
  // divisor (or below 2^32 for a zero divisor), so bit 32 of the difference
  // is a clean borrow flag.
  logic [32:0] div_diff;
  logic        div_ok;
  logic [31:0] rem_next;
  assign div_diff = {work[63:32], a_reg[31]} - {1'b0, b_reg};
  assign div_ok   = ~div_diff[32];
  assign rem_next = div_ok ? div_diff[31:0] : {work[62:32], a_reg[31]};

  // Sign fix-up applied in FIX
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  assign prod_fix = neg_res ? (~work + 64'd1) : work;
  assign quo_fix  = neg_res ? (~work[31:0] + 32'd1) : work[31:0];
  assign rem_fix  = neg_rem ? (~work[63:32] + 32'd1) : work[63:32];

  assign fsm_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= 2'd0;
      a_reg   <= 32'd0;
      b_reg   <= 32'd0;
      work    <= 64'd0;
      cnt     <= 6'd0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            a_reg <= a_mag_in;
            b_reg <= b_mag_in;
            work  <= 64'd0;
            cnt   <= 6'd0;
            // A zero divisor yields an all-ones quotient that must not be
            // negated. The remainder equals |A|, and restoring A's sign
            // gives back A unchanged, so neg_rem needs no exception.
            neg_res <= (a_neg_in ^ b_neg_in) & ~(in_div & (rtData == 32'd0));
            neg_rem <= in_div & a_neg_in;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            if (mthi) hi <= rsData;
            if (mtlo) lo <= rsData;
          end
        end

        RUN: begin
          if (op_q[1]) begin
            work  <= {rem_next, work[30:0], div_ok};
            a_reg <= {a_reg[30:0], 1'b0};
          end else begin
            work  <= {mul_sum, work[31:1]};
            b_reg <= {1'b0, b_reg[31:1]};
          end
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIX;
        end

        FIX: begin
          if (op_q[1]) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Directed and randomized checks of mult_div_unit against an arithmetic
//   reference model (64-bit integer multiply, truncating divide).
module tb_mult_div_unit;

  // Clock / reset
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic        mthi;
  logic        mtlo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic [1:0]  fsm_state;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .rsData    (rsData),
    .rtData    (rtData),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .fsm_state (fsm_state)
  );

  // Scoreboard
  int          tests = 0;
  int          fails = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference model: returns {hi, lo}
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'b00: begin
        sq = sa * sb;
        p  = sq;
      end
      2'b01: p = ua * ub;
      2'b10: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          p  = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          p  = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  // Driver: issue one op and follow it to completion.
  //   mt_with_start: raise mthi/mtlo in the issue cycle (must be dropped)
  //   disturb:       pulse start/mthi/mtlo mid-run (must be ignored)
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic mt_with_start, input logic disturb);
    logic [31:0] hi0, lo0;
    logic        ok;
    @(negedge clk);
    start  = 1'b1;
    op     = o;
    rsData = a;
    rtData = b;
    mthi   = mt_with_start;
    mtlo   = mt_with_start;
    exp_q.push_back(ref_model(o, a, b));
    hi0 = hi;
    lo0 = lo;
    @(negedge clk);
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    ok    = 1'b1;
    // After E0 .. E32: busy high, no done, HI/LO untouched
    for (int i = 0; i <= 32; i++) begin
      if (busy !== 1'b1 || done !== 1'b0 || hi !== hi0 || lo !== lo0) ok = 1'b0;
      if (disturb && i == 5) begin
        start = 1'b1; op = 2'b11; mthi = 1'b1; mtlo = 1'b1;
        rsData = 32'hDEAD_BEEF; rtData = 32'd1;
      end
      if (disturb && i == 6) begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
      @(negedge clk);
    end
    check("busy_hold", {71'd0, ok}, 72'd1);
    // After E33: result written, done pulse, busy low
    check("done_pulse", {70'd0, busy, done}, 72'b01);
    check("result", {8'd0, hi, lo}, {8'd0, exp_q.pop_front()});
    @(negedge clk);
    check("done_clear", {71'd0, done}, 72'd0);
  endtask

  logic [1:0]  r_op;
  logic [31:0] r_a, r_b, lo_prev;
  logic        quiet;

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; rsData = 32'd0; rtData = 32'd0;
    mthi = 1'b0; mtlo = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_vals", {4'd0, hi, lo, busy, done, fsm_state}, 72'd0);
    rst = 1'b0;

    // Directed arithmetic
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 1'b0);
    check("mult_neg3x5", {8'd0, hi, lo}, {8'd0, 64'hFFFF_FFFF_FFFF_FFF1});
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("multu_max", {8'd0, hi, lo}, {8'd0, 64'hFFFF_FFFE_0000_0001});
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("mult_m1xm1", {8'd0, hi, lo}, {8'd0, 64'h0000_0000_0000_0001});
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
    check("div_neg7by2", {8'd0, hi, lo}, {8'd0, 64'hFFFF_FFFF_FFFF_FFFD});
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("div_ovf", {8'd0, hi, lo}, {8'd0, 64'h0000_0000_8000_0000});
    run_op(2'b11, 32'h0000_0064, 32'h0000_0000, 1'b0, 1'b0);
    check("divu_by0", {8'd0, hi, lo}, {8'd0, 64'h0000_0064_FFFF_FFFF});
    run_op(2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 1'b0, 1'b0);
    check("div_by0", {8'd0, hi, lo}, {8'd0, 64'hFFFF_FFFB_FFFF_FFFF});

    // MTHI alone, then both together
    @(negedge clk);
    lo_prev = lo;
    rsData = 32'h1234_5678; mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi", {8'd0, hi, lo}, {8'd0, 32'h1234_5678, lo_prev});
    rsData = 32'hA5A5_0F0F; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check("mthi_mtlo", {8'd0, hi, lo}, {8'd0, 64'hA5A5_0F0F_A5A5_0F0F});

    // start with mt writes (mt dropped) and mid-run disturbance (ignored)
    run_op(2'b01, 32'd9, 32'd11, 1'b1, 1'b0);
    run_op(2'b01, 32'd2, 32'd3, 1'b0, 1'b1);
    check("ignore_busy", {8'd0, hi, lo}, {8'd0, 64'h0000_0000_0000_0006});

    // Reset mid-operation
    @(negedge clk);
    start = 1'b1; op = 2'b00; rsData = 32'd7; rtData = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_reset", {4'd0, hi, lo, busy, done, fsm_state}, 72'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    check("no_done_after_abort", {71'd0, quiet}, 72'd1);
    run_op(2'b01, 32'd7, 32'd7, 1'b0, 1'b0);
    check("multu_7x7", {8'd0, hi, lo}, {8'd0, 64'h0000_0000_0000_0031});

    // Randomized ops with boundary-biased operands
    for (int n = 0; n < 30; n++) begin
      r_op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: r_a = 32'h8000_0000;
        1: r_a = 32'hFFFF_FFFF;
        default: r_a = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: r_b = 32'd0;
        1: r_b = 32'hFFFF_FFFF;
        2: r_b = 32'($urandom_range(1, 15));
        default: r_b = $urandom;
      endcase
      run_op(r_op, r_a, r_b, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
